// File: rtl/instr_fetch_seq_if.sv
// instr_fetch_seq_if: program-memory read port plus control-unit Run/Done handshake.
interface instr_fetch_seq_if #(parameter int AW = 5, parameter int DW = 9);
    logic          Start;
    logic          Done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] DIN;
    logic          Run;
    logic [AW-1:0] pc;
    logic          Busy;
    logic          Halted;
    logic          Error;
    modport master (input Start, Done, mem_q,
                    output mem_addr, mem_rd, DIN, Run, pc, Busy, Halted, Error);
    modport slave  (output Start, Done, mem_q,
                    input mem_addr, mem_rd, DIN, Run, pc, Busy, Halted, Error);
endinterface

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: fetches instructions (and mvi immediates) and hands them to the control unit.
// Optional EXEC watchdog enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_seq #(
    parameter int AW         = 5,
    parameter int DW         = 9,
    parameter int START_ADDR = 0,
    parameter int TIMEOUT    = 16
) (
    input logic clk,
    input logic Resetn,
    instr_fetch_seq_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] F_ADDR = 3'd1;
    localparam logic [2:0] F_DATA = 3'd2;
    localparam logic [2:0] I_ADDR = 3'd3;
    localparam logic [2:0] I_DATA = 3'd4;
    localparam logic [2:0] ISSUE  = 3'd5;
    localparam logic [2:0] EXEC   = 3'd6;
    localparam logic [2:0] HALT   = 3'd7;

    logic [2:0]    state, nxt;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] ir_q, imm_q;
    logic          is_mvi, timeout;

    assign is_mvi = ir_q[DW-1:DW-3] == 3'b001;

    always_ff @(posedge clk or negedge Resetn)
        if (!Resetn) begin
            state <= IDLE;
            pc_q  <= AW'(START_ADDR);
            ir_q  <= '0;
            imm_q <= '0;
        end else begin
            state <= nxt;
            if (state == F_DATA) ir_q <= bus.mem_q;
            if (state == I_DATA) imm_q <= bus.mem_q;
            if (state == EXEC && bus.Done) pc_q <= pc_q + AW'(is_mvi ? 2 : 1);
        end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = bus.Start ? F_ADDR : IDLE;
            F_ADDR:  nxt = F_DATA;
            F_DATA:  nxt = &bus.mem_q ? HALT : bus.mem_q[DW-1:DW-3] == 3'b001 ? I_ADDR : ISSUE;
            I_ADDR:  nxt = I_DATA;
            I_DATA:  nxt = ISSUE;
            ISSUE:   nxt = EXEC;
            EXEC:    nxt = bus.Done ? (bus.Start ? F_ADDR : IDLE) : timeout ? HALT : EXEC;
            default: nxt = HALT;
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
    logic          err;
    // Done on the final counted cycle takes priority over the timeout
    assign timeout   = state == EXEC && cnt == CW'(TIMEOUT - 1);
    assign bus.Error = err;
    always_ff @(posedge clk or negedge Resetn)
        if (!Resetn) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state == ISSUE) cnt <= '0;
            else if (state == EXEC && !bus.Done) cnt <= cnt + 1'b1;
            if (timeout && !bus.Done) err <= 1'b1;
        end
`else
    assign timeout   = 1'b0;
    assign bus.Error = 1'b0;
`endif

    assign bus.mem_addr = state == F_ADDR ? pc_q : state == I_ADDR ? pc_q + AW'(1) : '0;
    assign bus.mem_rd   = state == F_ADDR || state == I_ADDR;
    assign bus.DIN      = state == ISSUE ? ir_q : state == EXEC ? (is_mvi ? imm_q : ir_q) : '0;
    assign bus.Run      = state == ISSUE;
    assign bus.pc       = pc_q;
    assign bus.Busy     = state != IDLE && state != HALT;
    assign bus.Halted   = state == HALT;
endmodule

// File: tb/tb_instr_fetch_seq.sv
// tb_instr_fetch_seq: random programs checked against a program-counter level model of the fetch rules.
module tb_instr_fetch_seq;
    logic clk = 1'b0;
    logic Resetn = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_seq_if b ();
    instr_fetch_seq dut (.clk(clk), .Resetn(Resetn), .bus(b.master));

    logic [8:0] mem [32];
    int mpc, n_chk, n_fail;

    always @(posedge clk) if (b.mem_rd) b.mem_q <= mem[b.mem_addr];

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    function automatic bit mvi_at(int a);
        return mem[a % 32][8:6] == 3'b001;
    endfunction

    function automatic logic [8:0] rnd_word(bit allow_mvi);
        logic [8:0] w;
        do w = 9'($urandom_range(0, 510)); while (w[8:6] == 3'b001);
        if (allow_mvi && $urandom_range(0, 2) == 0) w[8:6] = 3'b001;
        return w;
    endfunction

    task automatic chk_zero(string tag);
        chk({tag, "_run"}, b.Run, 0);
        chk({tag, "_busy"}, b.Busy, 0);
        chk({tag, "_halted"}, b.Halted, 0);
        chk({tag, "_error"}, b.Error, 0);
        chk({tag, "_din"}, b.DIN, 0);
        chk({tag, "_addr"}, b.mem_addr, 0);
        chk({tag, "_rd"}, b.mem_rd, 0);
        chk({tag, "_pc"}, b.pc, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Resetn = 1'b0;
        b.Start = 1'b0;
        b.Done = 1'b0;
        #1 chk_zero("reset");
        @(negedge clk);
        Resetn = 1'b1;
        mpc = 0;
    endtask

    // Expect Run with the word at the model pc; 3 cycles for plain, 5 for mvi.
    task automatic wait_run();
        int c = 0;
        int l = mvi_at(mpc) ? 5 : 3;
        do begin
            @(negedge clk);
            c++;
            b.Done = 1'b0;
        end while (!b.Run && c < 12);
        chk("latency", c, l);
        chk("issue_din", b.DIN, mem[mpc]);
        chk("issue_pc", b.pc, mpc);
        chk("issue_busy", b.Busy, 1);
    endtask

    task automatic step(int dly, bit stop);
        logic [8:0] ed = mvi_at(mpc) ? mem[(mpc + 1) % 32] : mem[mpc];
        for (int i = 0; i <= dly; i++) begin
            @(negedge clk);
            chk("exec_din", b.DIN, ed);
            chk("exec_run", b.Run, 0);
        end
        b.Done = 1'b1;
        b.Start = !stop;
        mpc = (mpc + (mvi_at(mpc) ? 2 : 1)) % 32;
        if (stop) begin
            @(negedge clk);
            b.Done = 1'b0;
            @(negedge clk);
            chk("stopped_busy", b.Busy, 0);
            chk("stopped_pc", b.pc, mpc);
            b.Start = 1'b1;
        end
        if (mem[mpc] != 9'h1FF) wait_run();
    endtask

    task automatic check_halt();
        bit seen = 0;
        @(negedge clk);
        b.Done = 1'b0;
        repeat (3) @(negedge clk);
        chk("halted", b.Halted, 1);
        chk("halt_busy", b.Busy, 0);
        chk("halt_pc", b.pc, mpc);
        b.Start = 1'b0;
        @(negedge clk);
        b.Start = 1'b1;
        repeat (8) begin
            @(negedge clk);
            seen |= b.Run;
        end
        chk("halt_norun", seen, 0);
        chk("halt_stays", b.Halted, 1);
    endtask

    initial begin
        b.Start = 1'b0;
        b.Done = 1'b0;
        foreach (mem[i]) mem[i] = '0;
        repeat (2) @(negedge clk);
        chk_zero("por");
        Resetn = 1'b1;
        mpc = 0;

        // two ordinary instructions then the halt word
        mem[0] = 9'b000_001_010;
        mem[1] = 9'h0C3;
        mem[2] = 9'h1FF;
        @(negedge clk);
        b.Start = 1'b1;
        wait_run();
        step(1, 0);
        step(0, 0);
        check_halt();
        do_reset();

        // mvi with immediate
        mem[0] = 9'b001_011_000;
        mem[1] = 9'h0A5;
        mem[2] = 9'h1FF;
        b.Start = 1'b1;
        wait_run();
        step(2, 0);
        check_halt();
        do_reset();

        // mvi at the top address takes its immediate from address 0
        for (int a = 0; a < 31; a++) mem[a] = rnd_word(0);
        mem[31] = {3'b001, 6'($urandom_range(0, 63))};
        b.Start = 1'b1;
        wait_run();
        repeat (32) step($urandom_range(0, 2), $urandom_range(0, 7) == 0);
        do_reset();

        // random programs with random Done delays and Start drops
        foreach (mem[i]) mem[i] = rnd_word(1);
        b.Start = 1'b1;
        wait_run();
        repeat (80) step($urandom_range(0, 3), $urandom_range(0, 5) == 0);

        // asynchronous reset during EXEC, then restart from address 0
        @(negedge clk);
        #2 Resetn = 1'b0;
        #1 chk_zero("midexec");
        @(negedge clk);
        Resetn = 1'b1;
        mpc = 0;
        wait_run();

        // Done on the 16th EXEC cycle advances normally
        step(15, 0);
        chk("late_done_err", b.Error, 0);

        // Done never arrives
        repeat (16) begin
            @(negedge clk);
            chk("wait_err", b.Error, 0);
            chk("wait_run", b.Run, 0);
        end
        @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
        chk("timeout_err", b.Error, 1);
        chk("timeout_halt", b.Halted, 1);
`else
        chk("notimeout_err", b.Error, 0);
        chk("notimeout_busy", b.Busy, 1);
`endif
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
